// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types for the LED pattern generator:
//   mode_e     : animation mode encoding as seen on the mode input
//   hs_state_e : request handshake FSM state
// ---------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      STATIC = 2'd0,
      BLINK  = 2'd1,
      CHASE  = 2'd2,
      BOUNCE = 2'd3
   } mode_e;

   typedef enum logic {
      ST_READY = 1'b0,
      ST_LOAD  = 1'b1
   } hs_state_e;

endpackage : led_pkg

// File: rtl/led_pattern_gen_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running clock divider producing one pattern tick every DIV enabled
// cycles.
// Ports:
//   CLK   in  : clock
//   rst_n in  : asynchronous active-low reset
//   en    in  : count enable; low freezes the counter and suppresses tick
//   clr   in  : synchronous clear of the counter (restarts the tick period)
//   tick  out : one-cycle pulse on the enabled cycle where the count is DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 25000000
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   // Divider counter: clear has priority, wraps to zero after DIV-1.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Tick is decoded straight from the count register so the consumer sees
   // it in the same cycle the count reaches DIV-1 (DIV=1 ticks every cycle).
   assign tick = en && (cnt_r == CNT_LAST);

endmodule : tick_gen

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Drives N_LED LEDs with one of four animations (static, blink, chase,
// bounce), selected through a valid/ready request interface.
// Ports:
//   CLK        in  : clock, all state on rising edge
//   rst_n      in  : asynchronous active-low reset
//   en         in  : animation enable; low freezes the animation
//   mode       in  : requested mode (led_pkg::mode_e encoding)
//   pattern    in  : base pattern for STATIC and BLINK
//   mode_valid in  : request strobe for mode/pattern
//   mode_ready out : high when a request can be accepted
//   LED        out : registered LED drive, bit 0 = LED0
// ---------------------------------------------------------------------------
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int N_LED = 3,
   parameter int DIV   = 25000000
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [N_LED-1:0] pattern,
   input  logic             mode_valid,
   output logic             mode_ready,
   output logic [N_LED-1:0] LED
);

   localparam int            PW       = (N_LED > 1) ? $clog2(N_LED) : 1;
   localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);
   localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};

   hs_state_e        state_r, state_nxt_s;
   logic             accept_s;
   logic             ready_s;
   logic             tick_s;
   logic             step_s;

   mode_e            mode_r, mode_nxt_s;
   logic [N_LED-1:0] pat_r, pat_nxt_s;
   logic             phase_r, phase_nxt_s;
   logic [PW-1:0]    pos_r, pos_nxt_s;
   logic             dir_up_r, dir_up_nxt_s;
   logic [N_LED-1:0] onehot_s;
   logic [N_LED-1:0] led_nxt_s;
   logic [N_LED-1:0] led_r;

   // Divider restarts on accept so a new mode always gets a full first period.
   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .CLK   (CLK),
      .rst_n (rst_n),
      .en    (en),
      .clr   (accept_s),
      .tick  (tick_s)
   );

   // Handshake FSM state register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_READY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Handshake FSM next state, accept strobe and ready output.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      ready_s     = 1'b0;
      case (state_r)
         ST_READY: begin
            ready_s = 1'b1;
            if (mode_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_READY;
            end
         end
         ST_LOAD: begin
            // Requests seen here are ignored; the requester keeps holding.
            state_nxt_s = ST_READY;
         end
         default: begin
            state_nxt_s = ST_READY;
         end
      endcase
   end

   assign mode_ready = ready_s;

   // Animation next state: accept reloads everything and swallows a
   // coincident tick; otherwise a tick advances the current mode.
   always_comb begin
      mode_nxt_s   = mode_r;
      pat_nxt_s    = pat_r;
      phase_nxt_s  = phase_r;
      pos_nxt_s    = pos_r;
      dir_up_nxt_s = dir_up_r;
      step_s       = tick_s && !accept_s;
      if (accept_s) begin
         mode_nxt_s   = mode_e'(mode);
         pat_nxt_s    = pattern;
         phase_nxt_s  = 1'b0;
         pos_nxt_s    = POS_ZERO;
         dir_up_nxt_s = 1'b1;
      end else if (step_s) begin
         case (mode_r)
            STATIC: begin
               phase_nxt_s = phase_r;
            end
            BLINK: begin
               phase_nxt_s = !phase_r;
            end
            CHASE: begin
               if (pos_r == POS_LAST) begin
                  pos_nxt_s = POS_ZERO;
               end else begin
                  pos_nxt_s = pos_r + PW'(1);
               end
            end
            BOUNCE: begin
               if (N_LED == 1) begin
                  pos_nxt_s = POS_ZERO;
               end else if (dir_up_r) begin
                  // Reverse at the top end without lighting it twice.
                  if (pos_r == POS_LAST) begin
                     dir_up_nxt_s = 1'b0;
                     pos_nxt_s    = pos_r - PW'(1);
                  end else begin
                     pos_nxt_s = pos_r + PW'(1);
                  end
               end else begin
                  if (pos_r == POS_ZERO) begin
                     dir_up_nxt_s = 1'b1;
                     pos_nxt_s    = pos_r + PW'(1);
                  end else begin
                     pos_nxt_s = pos_r - PW'(1);
                  end
               end
            end
            default: begin
               pos_nxt_s = pos_r;
            end
         endcase
      end else begin
         step_s = 1'b0;
      end
   end

   // One-hot decode of the next position for CHASE and BOUNCE.
   always_comb begin
      onehot_s = {N_LED{1'b0}};
      for (int i = 0; i < N_LED; i++) begin
         onehot_s[i] = (pos_nxt_s == PW'(i));
      end
   end

   // LED value derived from the next animation state, so the register
   // already shows the new mode's initial value on the cycle after accept.
   always_comb begin
      led_nxt_s = {N_LED{1'b0}};
      case (mode_nxt_s)
         STATIC:  led_nxt_s = pat_nxt_s;
         BLINK:   led_nxt_s = phase_nxt_s ? ~pat_nxt_s : pat_nxt_s;
         CHASE:   led_nxt_s = onehot_s;
         BOUNCE:  led_nxt_s = onehot_s;
         default: led_nxt_s = {N_LED{1'b0}};
      endcase
   end

   // Animation state and LED registers.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         mode_r   <= STATIC;
         pat_r    <= {N_LED{1'b0}};
         phase_r  <= 1'b0;
         pos_r    <= POS_ZERO;
         dir_up_r <= 1'b1;
         led_r    <= {N_LED{1'b0}};
      end else begin
         mode_r   <= mode_nxt_s;
         pat_r    <= pat_nxt_s;
         phase_r  <= phase_nxt_s;
         pos_r    <= pos_nxt_s;
         dir_up_r <= dir_up_nxt_s;
         led_r    <= led_nxt_s;
      end
   end

   assign LED = led_r;

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Scoreboard bench for led_pattern_gen with N_LED=4, DIV=4. The stimulus
// thread pushes the expected {LED, mode_ready} for the cycle after each
// edge; a negedge monitor pops and compares entries whose cycle has come.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] pattern = 4'b0000;
   logic       mode_valid = 1'b0;
   logic       mode_ready;
   logic [3:0] LED;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   typedef struct {
      int         cyc;
      logic [3:0] led;
      logic       rdy;
      string      name;
   } exp_t;

   exp_t q[$];

   led_pattern_gen #(
      .N_LED (4),
      .DIV   (4)
   ) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .pattern    (pattern),
      .mode_valid (mode_valid),
      .mode_ready (mode_ready),
      .LED        (LED)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got LED/ready=%b/%b expected %b/%b",
                  name, cyc_cnt, act[4:1], act[0], exp[4:1], exp[0]);
      end
   endtask

   // Monitor: compare every expectation whose target cycle has arrived.
   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
         exp_t e;
         e = q.pop_front();
         if (e.cyc != cyc_cnt) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: stale entry for cyc %0d at cyc %0d", e.name, e.cyc, cyc_cnt);
         end else begin
            check(e.name, {LED, mode_ready}, {e.led, e.rdy});
         end
      end
   end

   // Queue the expectation for after the next edge, then advance one cycle.
   task automatic push_step(input logic [3:0] led, input logic rdy, input string name);
      exp_t e;
      e.cyc  = cyc_cnt + 1;
      e.led  = led;
      e.rdy  = rdy;
      e.name = name;
      q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic run(input logic [3:0] led, input int n, input string name);
      for (int i = 0; i < n; i++) push_step(led, 1'b1, name);
   endtask

   // Single-cycle request; live inputs are then scrambled to show they are
   // ignored outside an accept.
   task automatic accept(input logic [1:0] m, input logic [3:0] p,
                         input logic [3:0] init, input string name);
      mode       = m;
      pattern    = p;
      mode_valid = 1'b1;
      push_step(init, 1'b0, name);
      mode_valid = 1'b0;
      mode       = 2'd3;
      pattern    = 4'b1110;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check("reset", {LED, mode_ready}, {4'b0000, 1'b1});
      rst_n = 1'b1;
      run(4'b0000, 2, "idle_after_reset");

      // STATIC 1010 holds through ticks
      en = 1'b1;
      accept(2'd0, 4'b1010, 4'b1010, "static_accept");
      run(4'b1010, 20, "static_hold");

      // BLINK 0011
      accept(2'd1, 4'b0011, 4'b0011, "blink_accept");
      run(4'b0011, 3, "blink_p0");
      run(4'b1100, 4, "blink_p1");
      run(4'b0011, 4, "blink_p0b");
      run(4'b1100, 4, "blink_p1b");

      // CHASE with an en=0 hold
      accept(2'd2, 4'b0000, 4'b0001, "chase_accept");
      run(4'b0001, 3, "chase_0");
      run(4'b0010, 4, "chase_1");
      run(4'b0100, 4, "chase_2");
      run(4'b1000, 4, "chase_3");
      run(4'b0001, 3, "chase_wrap");
      en = 1'b0;
      run(4'b0001, 10, "chase_en_low");
      en = 1'b1;
      run(4'b0001, 1, "chase_resume");
      run(4'b0010, 4, "chase_after_hold");

      // BOUNCE
      accept(2'd3, 4'b0000, 4'b0001, "bounce_accept");
      run(4'b0001, 3, "bounce_0");
      run(4'b0010, 4, "bounce_1");
      run(4'b0100, 4, "bounce_2");
      run(4'b1000, 4, "bounce_3");
      run(4'b0100, 4, "bounce_2r");
      run(4'b0010, 4, "bounce_1r");
      run(4'b0001, 4, "bounce_0r");
      run(4'b0010, 4, "bounce_1b");

      // Request held into LOAD is not taken
      mode       = 2'd1;
      pattern    = 4'b0101;
      mode_valid = 1'b1;
      push_step(4'b0101, 1'b0, "load_accept");
      mode    = 2'd2;
      pattern = 4'b1111;
      push_step(4'b0101, 1'b1, "load_ignored");
      mode_valid = 1'b0;
      run(4'b0101, 2, "load_blink_p0");
      run(4'b1010, 4, "load_blink_p1");

      // Accept on a tick cycle: tick discarded, initial value shown
      accept(2'd2, 4'b0000, 4'b0001, "tick_accept");
      run(4'b0001, 3, "tick_accept_hold");
      run(4'b0010, 1, "tick_accept_step");

      // Accept while en=0 loads the initial value, resumes on en=1
      en = 1'b0;
      accept(2'd0, 4'b0110, 4'b0110, "en0_static");
      run(4'b0110, 2, "en0_static_hold");
      accept(2'd1, 4'b1001, 4'b1001, "en0_blink");
      run(4'b1001, 5, "en0_blink_hold");
      en = 1'b1;
      run(4'b1001, 3, "en1_blink_p0");
      run(4'b0110, 2, "en1_blink_p1");

      // Asynchronous reset mid-BOUNCE
      accept(2'd3, 4'b0000, 4'b0001, "rst_bounce_accept");
      run(4'b0001, 3, "rst_bounce_0");
      run(4'b0010, 4, "rst_bounce_1");
      run(4'b0100, 2, "rst_bounce_2");
      @(negedge CLK);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", {LED, mode_ready}, {4'b0000, 1'b1});
      @(posedge CLK);
      #1;
      rst_n = 1'b1;
      run(4'b0000, 3, "after_reset_idle");

      // Drain the scoreboard
      repeat (2) @(posedge CLK);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_led_pattern_gen
